apb_mst_fsm_mc: RTL and testbench

//  APB3 completer front-end that bridges one APB port to SLV_NUM external register slaves,

---
 rtl/apb_mst_fsm_mc_if.sv | 27 ++
 rtl/apb_mst_fsm_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_apb_mst_fsm_mc.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mst_fsm_mc_if.sv
// APB3 bus bundle for apb_mst_fsm_mc; PSTRB exists only when APB_MST_FSM_PSTRB_EN is defined.
interface apb_mst_fsm_mc_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PWRITE;
  logic                    PSEL;
  logic                    PENABLE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
`ifdef APB_MST_FSM_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;

  modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR);
`else
  modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
`endif
endinterface

// File: rtl/apb_mst_fsm_mc.sv
// APB3 completer bridging one APB port to SLV_NUM req/ack register slaves with decode error and timeout.
// Optional byte strobes: define APB_MST_FSM_PSTRB_EN.
module apb_mst_fsm_mc #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SLV_NUM    = 4,
  parameter int unsigned TIMECNT    = 99,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [31:0] ERR_DATA   = 32'hdead_1eaf
) (
  input  logic                          clk,
  input  logic                          rstn,
  apb_mst_fsm_mc_if.slave               apb,
  input  logic [SLV_NUM-1:0]            slv_sel,
  output logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
  output logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
`ifdef APB_MST_FSM_PSTRB_EN
  output logic [DATA_WIDTH/8-1:0]       fsm__slv__wr_strb,
`endif
  output logic                          fsm__slv__wr_en,
  output logic                          fsm__slv__rd_en,
  output logic [SLV_NUM-1:0]            fsm__slv__req_vld,
  input  logic [SLV_NUM-1:0]            slv__fsm__req_rdy,
  input  logic [SLV_NUM-1:0]            slv__fsm__ack_vld,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] slv__fsm__rd_data,
  output logic                          fsm__slv__ack_rdy,
  output logic [SLV_NUM-1:0]            fsm__slv__sync_reset,
  input  logic                          clear,
  output logic                          interrupt,
  output logic [ADDR_WIDTH-1:0]         timeout_addr
);

  localparam logic [DATA_WIDTH-1:0] ERR_D   = DATA_WIDTH'(ERR_DATA);
  localparam logic [CNT_WIDTH-1:0]  CNT_END = CNT_WIDTH'(TIMECNT);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, WAIT_ACK, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SLV_NUM-1:0]      sel_q, sel_d;
  logic [SLV_NUM-1:0]      req_vld_q, req_vld_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    ack_rdy_q, ack_rdy_d;
  logic [SLV_NUM-1:0]      sync_rst_q, sync_rst_d;
  logic                    intr_q, intr_d;
  logic [ADDR_WIDTH-1:0]   to_addr_q, to_addr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    sel_onehot;
  logic                    decode_err;
  logic                    rdy_hit;
  logic                    ack_hit;
  logic                    expire;
  logic [DATA_WIDTH-1:0]   sel_rdata;
`ifdef APB_MST_FSM_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
`endif

  assign sel_onehot = (slv_sel != '0) && ((slv_sel & (slv_sel - SLV_NUM'(1))) == '0);
`ifdef APB_MST_FSM_PSTRB_EN
  assign decode_err = !sel_onehot || (!apb.PWRITE && (apb.PSTRB != '0));
`else
  assign decode_err = !sel_onehot;
`endif

  // Masking with the latched one-hot select makes every unselected slave invisible.
  assign rdy_hit = |(slv__fsm__req_rdy & sel_q);
  assign ack_hit = |(slv__fsm__ack_vld & sel_q);
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign expire  = (cnt_inc == CNT_END);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (sel_q[i]) sel_rdata |= slv__fsm__rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    req_vld_d  = req_vld_q;
    wr_en_d    = wr_en_q;
    rd_en_d    = rd_en_q;
    ack_rdy_d  = ack_rdy_q;
    sync_rst_d = '0;
    intr_d     = intr_q;
    to_addr_d  = to_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef APB_MST_FSM_PSTRB_EN
    strb_d     = strb_q;
`endif

    if (clear) begin
      intr_d    = 1'b0;
      to_addr_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          if (decode_err) begin
            err_d   = 1'b1;
            rdata_d = ERR_D;
            state_d = RESP;
          end else begin
            addr_d    = apb.PADDR;
            wdata_d   = apb.PWDATA;
`ifdef APB_MST_FSM_PSTRB_EN
            strb_d    = apb.PSTRB;
`endif
            sel_d     = slv_sel;
            req_vld_d = slv_sel;
            wr_en_d   = apb.PWRITE;
            rd_en_d   = !apb.PWRITE;
            cnt_d     = '0;
            state_d   = WAIT_RDY;
          end
        end
      end

      WAIT_RDY, WAIT_ACK: begin
        cnt_d = cnt_inc;
        // Completion is tested before expiry so a same-cycle ack beats the timeout.
        if ((state_q == WAIT_RDY && rdy_hit && ack_hit) || (state_q == WAIT_ACK && ack_hit)) begin
          rdata_d   = sel_rdata;
          err_d     = 1'b0;
          req_vld_d = '0;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          ack_rdy_d = 1'b0;
          state_d   = RESP;
        end else if (expire) begin
          rdata_d    = ERR_D;
          err_d      = 1'b1;
          req_vld_d  = '0;
          wr_en_d    = 1'b0;
          rd_en_d    = 1'b0;
          ack_rdy_d  = 1'b0;
          sync_rst_d = sel_q;
          intr_d     = 1'b1;
          to_addr_d  = addr_q;
          state_d    = RESP;
        end else if (state_q == WAIT_RDY && rdy_hit) begin
          req_vld_d = '0;
          wr_en_d   = 1'b0;
          rd_en_d   = 1'b0;
          ack_rdy_d = 1'b1;
          state_d   = WAIT_ACK;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      req_vld_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      ack_rdy_q  <= 1'b0;
      sync_rst_q <= '0;
      intr_q     <= 1'b0;
      to_addr_q  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef APB_MST_FSM_PSTRB_EN
      strb_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      req_vld_q  <= req_vld_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      ack_rdy_q  <= ack_rdy_d;
      sync_rst_q <= sync_rst_d;
      intr_q     <= intr_d;
      to_addr_q  <= to_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef APB_MST_FSM_PSTRB_EN
      strb_q     <= strb_d;
`endif
    end
  end

  assign apb.PREADY  = (state_q == RESP);
  assign apb.PRDATA  = (state_q == RESP) ? rdata_q : '0;
  assign apb.PSLVERR = (state_q == RESP) && err_q;

  assign fsm__slv__addr       = addr_q;
  assign fsm__slv__wr_data    = wdata_q;
`ifdef APB_MST_FSM_PSTRB_EN
  assign fsm__slv__wr_strb    = strb_q;
`endif
  assign fsm__slv__wr_en      = wr_en_q;
  assign fsm__slv__rd_en      = rd_en_q;
  assign fsm__slv__req_vld    = req_vld_q;
  assign fsm__slv__ack_rdy    = ack_rdy_q;
  assign fsm__slv__sync_reset = sync_rst_q;
  assign interrupt            = intr_q;
  assign timeout_addr         = to_addr_q;

endmodule

// File: tb/tb_apb_mst_fsm_mc.sv
// Table-driven bench for apb_mst_fsm_mc: directed APB transfers with hand-computed responses,
// plus reset-state and mid-transfer reset sequences.
module tb_apb_mst_fsm_mc;
  localparam int NEVER = 255;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   slv_sel;
  logic [63:0]  slv_addr;
  logic [31:0]  slv_wr_data;
  logic         slv_wr_en, slv_rd_en, ack_rdy, clear, interrupt;
  logic [3:0]   req_vld, req_rdy, ack_vld, sync_reset;
  logic [127:0] rd_data;
  logic [63:0]  timeout_addr;
`ifdef APB_MST_FSM_PSTRB_EN
  logic [3:0]   wr_strb;
`endif

  int n_chk = 0;
  int n_err = 0;

  apb_mst_fsm_mc_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) apb ();

  apb_mst_fsm_mc #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .SLV_NUM(4), .TIMECNT(99), .CNT_WIDTH(16),
    .ERR_DATA(32'hdead_1eaf)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .apb                  (apb),
    .slv_sel              (slv_sel),
    .fsm__slv__addr       (slv_addr),
    .fsm__slv__wr_data    (slv_wr_data),
`ifdef APB_MST_FSM_PSTRB_EN
    .fsm__slv__wr_strb    (wr_strb),
`endif
    .fsm__slv__wr_en      (slv_wr_en),
    .fsm__slv__rd_en      (slv_rd_en),
    .fsm__slv__req_vld    (req_vld),
    .slv__fsm__req_rdy    (req_rdy),
    .slv__fsm__ack_vld    (ack_vld),
    .slv__fsm__rd_data    (rd_data),
    .fsm__slv__ack_rdy    (ack_rdy),
    .fsm__slv__sync_reset (sync_reset),
    .clear                (clear),
    .interrupt            (interrupt),
    .timeout_addr         (timeout_addr)
  );

  always #5 clk = ~clk;

  // r / a: window (counted from the setup-sampling edge) in which the selected slave pulses req_rdy / ack_vld.
  typedef struct {
    bit          wr;
    logic [3:0]  sel;
    logic [63:0] addr;
    logic [31:0] wdata;
    int          r;
    int          a;
    logic [31:0] sdata;
    bit          noise;
    bit          drop;
    int          clr;
    int          lat;
    logic [31:0] prdata;
    bit          err;
    int          req_cnt;
    int          ack_cnt;
    logic [3:0]  sync;
    bit          intr;
    logic [63:0] toaddr;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [3:0] sel, logic [63:0] addr, logic [31:0] wdata,
                              int r, int a, logic [31:0] sdata, bit noise, bit drop, int clr,
                              int lat, logic [31:0] prdata, bit err, int req_cnt, int ack_cnt,
                              logic [3:0] sync, bit intr, logic [63:0] toaddr);
    vec_t v;
    v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata; v.r = r; v.a = a; v.sdata = sdata;
    v.noise = noise; v.drop = drop; v.clr = clr; v.lat = lat; v.prdata = prdata; v.err = err;
    v.req_cnt = req_cnt; v.ack_cnt = ack_cnt; v.sync = sync; v.intr = intr; v.toaddr = toaddr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat = -1;
    int          req_cnt = 0, ack_cnt = 0, sync_cnt = 0;
    logic [3:0]  sync_val = '0;
    logic [31:0] got_prdata = '0;
    logic        got_err = 1'b0;
    logic [3:0]  w0_req = '0;
    logic        w0_wr = 1'b0, w0_rd = 1'b0;
    logic [63:0] w0_addr = '0;
    logic [31:0] w0_wdata = '0;
    bit          done = 1'b0;
    bit          good = (v.req_cnt != 0);
    string       p = $sformatf("v%0d", idx);

    apb.PADDR = v.addr; apb.PWRITE = v.wr; apb.PWDATA = v.wdata;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
`ifdef APB_MST_FSM_PSTRB_EN
    apb.PSTRB = v.wr ? 4'hf : 4'h0;
`endif
    slv_sel = v.sel;
    rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.sel[i]) rd_data[i*32 +: 32] = v.sdata;
      else if (v.noise) rd_data[i*32 +: 32] = 32'hffff_ffff;
    end
    req_rdy = '0; ack_vld = '0; clear = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        w0_req = req_vld; w0_wr = slv_wr_en; w0_rd = slv_rd_en;
        w0_addr = slv_addr; w0_wdata = slv_wr_data;
      end
      if (req_vld != '0) req_cnt++;
      if (ack_rdy) ack_cnt++;
      if (sync_reset != '0) begin sync_cnt++; sync_val |= sync_reset; end
      if (lat >= 0 && k == lat + 1) begin
        check({p, " pready_one_cycle"}, {63'd0, apb.PREADY}, 64'd0);
        done = 1'b1;
      end else begin
        if (apb.PREADY && lat < 0) begin
          lat = k; got_prdata = apb.PRDATA; got_err = apb.PSLVERR;
          apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        end else if (lat < 0) begin
          apb.PSEL = !v.drop; apb.PENABLE = !v.drop;
        end
        req_rdy = (k == v.r) ? v.sel : 4'b0000;
        ack_vld = (k == v.a) ? v.sel : 4'b0000;
        if (v.noise) begin req_rdy |= ~v.sel; ack_vld |= ~v.sel; end
        clear = (k == v.clr);
      end
    end
    req_rdy = '0; ack_vld = '0; clear = 1'b0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;

    check({p, " latency"}, 64'(lat), 64'(v.lat));
    check({p, " prdata"}, 64'(got_prdata), 64'(v.prdata));
    check({p, " pslverr"}, {63'd0, got_err}, {63'd0, v.err});
    check({p, " req_vld_cycles"}, 64'(req_cnt), 64'(v.req_cnt));
    check({p, " ack_rdy_cycles"}, 64'(ack_cnt), 64'(v.ack_cnt));
    check({p, " sync_reset_val"}, 64'(sync_val), 64'(v.sync));
    check({p, " sync_reset_cycles"}, 64'(sync_cnt), (v.sync != '0) ? 64'd1 : 64'd0);
    check({p, " interrupt"}, {63'd0, interrupt}, {63'd0, v.intr});
    check({p, " timeout_addr"}, timeout_addr, v.toaddr);
    check({p, " req_vld_first"}, 64'(w0_req), good ? 64'(v.sel) : 64'd0);
    check({p, " wr_rd_en_first"}, {62'd0, w0_wr, w0_rd}, good ? {62'd0, v.wr, !v.wr} : 64'd0);
    if (good) begin
      check({p, " slv_addr"}, w0_addr, v.addr);
      check({p, " slv_wr_data"}, 64'(w0_wdata), 64'(v.wdata));
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " req_vld"}, 64'(req_vld), 64'd0);
    check({nm, " strobes"}, {62'd0, slv_wr_en, slv_rd_en}, 64'd0);
    check({nm, " ack_rdy"}, {63'd0, ack_rdy}, 64'd0);
    check({nm, " apb_resp"}, {31'd0, apb.PREADY, apb.PSLVERR, apb.PRDATA}, 64'd0);
    check({nm, " sync_reset"}, 64'(sync_reset), 64'd0);
    check({nm, " interrupt"}, {63'd0, interrupt}, 64'd0);
    check({nm, " timeout_addr"}, timeout_addr, 64'd0);
  endtask

  localparam logic [31:0] ED = 32'hdead_1eaf;
  localparam logic [63:0] A6 = 64'hABCD_0000_0000_0040;
  localparam logic [63:0] A8 = 64'h0000_1111_2222_0080;
  localparam logic [63:0] A10 = 64'h0000_0000_0000_00C0;

  vec_t vecs[11];

  initial begin
    //              wr  sel      addr                    wdata          r      a      sdata          nz drop clr    lat prdata         err req ack sync     intr toaddr
    vecs[0]  = mk(1, 4'b0100, 64'h0000_0000_1000_0010, 32'hA5A5_0001, 0,     0,     32'h0,         0, 0, NEVER, 1,  32'h0,         0, 1,  0,  4'b0000, 0, 64'h0);
    vecs[1]  = mk(0, 4'b0001, 64'h0000_0000_0000_0020, 32'h0,         3,     8,     32'h1234_5678, 0, 0, NEVER, 9,  32'h1234_5678, 0, 4,  5,  4'b0000, 0, 64'h0);
    vecs[2]  = mk(0, 4'b0000, 64'h0000_0000_0000_0030, 32'h0,         NEVER, NEVER, 32'h0,         0, 0, NEVER, 0,  ED,            1, 0,  0,  4'b0000, 0, 64'h0);
    vecs[3]  = mk(0, 4'b0110, 64'h0000_0000_0000_0034, 32'h0,         NEVER, NEVER, 32'h0,         0, 0, NEVER, 0,  ED,            1, 0,  0,  4'b0000, 0, 64'h0);
    vecs[4]  = mk(0, 4'b1000, 64'h0000_0000_0000_0044, 32'h0,         1,     1,     32'hCAFE_F00D, 1, 0, NEVER, 2,  32'hCAFE_F00D, 0, 2,  0,  4'b0000, 0, 64'h0);
    vecs[5]  = mk(1, 4'b0010, 64'h0000_0000_0000_0048, 32'h0F0F_1234, 2,     5,     32'h0,         0, 1, NEVER, 6,  32'h0,         0, 3,  3,  4'b0000, 0, 64'h0);
    vecs[6]  = mk(0, 4'b0010, A6,                      32'h0,         2,     NEVER, 32'h0,         0, 0, NEVER, 99, ED,            1, 3,  96, 4'b0010, 1, A6);
    vecs[7]  = mk(0, 4'b0100, 64'h0000_0000_0000_0050, 32'h0,         0,     98,    32'h0BAD_CAFE, 0, 0, NEVER, 99, 32'h0BAD_CAFE, 0, 1,  98, 4'b0000, 1, A6);
    vecs[8]  = mk(1, 4'b0001, A8,                      32'h9999_0000, NEVER, NEVER, 32'h0,         0, 0, 98,    99, ED,            1, 99, 0,  4'b0001, 1, A8);
    vecs[9]  = mk(0, 4'b1000, 64'h0000_0000_0000_0060, 32'h0,         0,     0,     32'h55AA_33CC, 0, 0, 0,     1,  32'h55AA_33CC, 0, 1,  0,  4'b0000, 0, 64'h0);
    vecs[10] = mk(0, 4'b0100, A10,                     32'h0,         0,     99,    32'h7777_7777, 0, 0, NEVER, 99, ED,            1, 1,  98, 4'b0100, 1, A10);

    apb.PADDR = '0; apb.PWRITE = 1'b0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWDATA = '0;
`ifdef APB_MST_FSM_PSTRB_EN
    apb.PSTRB = '0;
`endif
    slv_sel = '0; req_rdy = '0; ack_vld = '0; rd_data = '0; clear = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset slv_addr", slv_addr, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset asserted while waiting for an ack must drop the request side at once.
    apb.PADDR = 64'h70; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0; slv_sel = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("midrst req_vld_before", 64'(req_vld), 64'd1);
    apb.PENABLE = 1'b1; req_rdy = 4'b0001;
    @(negedge clk);
    req_rdy = '0;
    check("midrst ack_rdy_before", {63'd0, ack_rdy}, 64'd1);
    #1 rstn = 1'b0;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    rstn = 1'b1;
    run_vec(11, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
